// File: rtl/lock_cycle_ctrl.sv
// Lock-chamber cycle controller: synchronised arrive/depart requests, timed equalisation, then passage grant.
// Optional fair arbitration between simultaneous requests is enabled by defining LOCK_FAIR_ARB_EN.
module lock_cycle_ctrl #(
    parameter int unsigned PRESS_CYCLES = 7,
    parameter int unsigned CNT_W        = 10,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic arrive_switch,
    input  logic depart_switch,
    output logic press_up,
    output logic press_down,
    output logic arrive_signal,
    output logic depart_signal,
    output logic busy,
    output logic cycle_done
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_UP   = 3'd1,
        ARRIVE     = 3'd2,
        PRESS_DOWN = 3'd3,
        DEPART     = 3'd4
    } lockState_t;

    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);

    logic [SYNC_STAGES-1:0] arrSync;
    logic [SYNC_STAGES-1:0] depSync;
    logic                   arrS;
    logic                   depS;
    logic                   arbArrive;
    lockState_t             state;
    lockState_t             stateNext;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cntNext;
    logic                   doneNext;

    // Input synchroniser chains; only the last stage is seen by the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            arrSync <= '0;
            depSync <= '0;
        end else begin
            arrSync <= {arrSync[SYNC_STAGES-2:0], arrive_switch};
            depSync <= {depSync[SYNC_STAGES-2:0], depart_switch};
        end
    end

    assign arrS = arrSync[SYNC_STAGES-1];
    assign depS = depSync[SYNC_STAGES-1];

`ifdef LOCK_FAIR_ARB_EN
    logic lastDep;

    // Remembers the direction of the last completed grant; reset as departure so arrival wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastDep <= 1'b1;
        end else if (doneNext) begin
            lastDep <= (state == DEPART);
        end
    end

    assign arbArrive = lastDep;
`else
    assign arbArrive = 1'b1;
`endif

    // Next-state and counter logic.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        doneNext  = 1'b0;
        case (state)
            IDLE: begin
                cntNext = '0;
                if (arrS && (!depS || arbArrive)) begin
                    stateNext = PRESS_UP;
                end else if (depS) begin
                    stateNext = PRESS_DOWN;
                end
            end
            PRESS_UP: begin
                cntNext = cnt + CNT_W'(1);
                if (cnt == PRESS_LAST) begin
                    stateNext = ARRIVE;
                end
            end
            ARRIVE: begin
                if (!arrS) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            PRESS_DOWN: begin
                cntNext = cnt + CNT_W'(1);
                if (cnt == PRESS_LAST) begin
                    stateNext = DEPART;
                end
            end
            DEPART: begin
                if (!depS) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register; outputs are registered from the next state so they track the state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            press_up      <= 1'b0;
            press_down    <= 1'b0;
            arrive_signal <= 1'b0;
            depart_signal <= 1'b0;
            busy          <= 1'b0;
            cycle_done    <= 1'b0;
        end else begin
            state         <= stateNext;
            cnt           <= cntNext;
            press_up      <= (stateNext == PRESS_UP);
            press_down    <= (stateNext == PRESS_DOWN);
            arrive_signal <= (stateNext == ARRIVE);
            depart_signal <= (stateNext == DEPART);
            busy          <= (stateNext != IDLE);
            cycle_done    <= doneNext;
        end
    end

endmodule

// File: tb/tb_lock_cycle_ctrl.sv
// Bench for lock_cycle_ctrl: two instances (PRESS_CYCLES 7/SYNC 2 and 1/3) checked against a timer-based model.
module tb_lock_cycle_ctrl;

    localparam int unsigned PC0 = 7;
    localparam int unsigned SS0 = 2;
    localparam int unsigned PC1 = 1;
    localparam int unsigned SS1 = 3;

    logic clk = 1'b0;
    logic rst;
    logic arriveSw;
    logic departSw;
    logic [1:0] pu, pd, as, ds, bz, cd;

    int assertCount = 0;
    int failCount   = 0;
    bit started     = 1'b0;

    int pcOf [2];
    int ssOf [2];

    // Model: direction being served (0 none, 1 arrival, 2 departure), remaining equalisation cycles.
    int dir [2];
    int pressLeft [2];
    int last [2];
    bit doneExp [2];
    bit histA [2][4];
    bit histD [2][4];

    always #5 clk = ~clk;

    lock_cycle_ctrl #(.PRESS_CYCLES(PC0), .CNT_W(10), .SYNC_STAGES(SS0)) dut0 (
        .clk(clk), .rst(rst), .arrive_switch(arriveSw), .depart_switch(departSw),
        .press_up(pu[0]), .press_down(pd[0]), .arrive_signal(as[0]), .depart_signal(ds[0]),
        .busy(bz[0]), .cycle_done(cd[0])
    );

    lock_cycle_ctrl #(.PRESS_CYCLES(PC1), .CNT_W(4), .SYNC_STAGES(SS1)) dut1 (
        .clk(clk), .rst(rst), .arrive_switch(arriveSw), .depart_switch(departSw),
        .press_up(pu[1]), .press_down(pd[1]), .arrive_signal(as[1]), .depart_signal(ds[1]),
        .busy(bz[1]), .cycle_done(cd[1])
    );

    task automatic checkVal(input string tag, input int act, input int exp);
        assertCount++;
        if (act != exp) begin
            failCount++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit arrivalWins(input int i);
`ifdef LOCK_FAIR_ARB_EN
        return (last[i] != 1);
`else
        return 1'b1;
`endif
    endfunction

    task automatic modelStep(input int i);
        bit sa, sd;
        int ss;
        ss = ssOf[i];
        if (rst) begin
            dir[i] = 0;
            pressLeft[i] = 0;
            last[i] = 2;
            doneExp[i] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                histA[i][k] = 1'b0;
                histD[i][k] = 1'b0;
            end
            return;
        end
        sa = histA[i][ss-1];
        sd = histD[i][ss-1];
        for (int k = ss - 1; k > 0; k--) begin
            histA[i][k] = histA[i][k-1];
            histD[i][k] = histD[i][k-1];
        end
        histA[i][0] = arriveSw;
        histD[i][0] = departSw;
        doneExp[i] = 1'b0;
        if (dir[i] == 0) begin
            if (sa && sd) dir[i] = arrivalWins(i) ? 1 : 2;
            else if (sa) dir[i] = 1;
            else if (sd) dir[i] = 2;
            if (dir[i] != 0) pressLeft[i] = pcOf[i];
        end else if (pressLeft[i] > 0) begin
            pressLeft[i]--;
        end else if ((dir[i] == 1 && !sa) || (dir[i] == 2 && !sd)) begin
            doneExp[i] = 1'b1;
            last[i] = dir[i];
            dir[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) modelStep(i);
    end

    // Compare every output of both instances midway between edges.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                checkVal($sformatf("press_up%0d", i), int'(pu[i]), int'(dir[i] == 1 && pressLeft[i] > 0));
                checkVal($sformatf("press_down%0d", i), int'(pd[i]), int'(dir[i] == 2 && pressLeft[i] > 0));
                checkVal($sformatf("arrive_signal%0d", i), int'(as[i]), int'(dir[i] == 1 && pressLeft[i] == 0));
                checkVal($sformatf("depart_signal%0d", i), int'(ds[i]), int'(dir[i] == 2 && pressLeft[i] == 0));
                checkVal($sformatf("busy%0d", i), int'(bz[i]), int'(dir[i] != 0));
                checkVal($sformatf("cycle_done%0d", i), int'(cd[i]), int'(doneExp[i]));
                checkVal($sformatf("onehot%0d", i), int'($countones({pu[i], pd[i], as[i], ds[i]}) <= 1), 1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        pcOf[0] = PC0; pcOf[1] = PC1;
        ssOf[0] = SS0; ssOf[1] = SS1;
        rst = 1'b1;
        arriveSw = 1'b0;
        departSw = 1'b0;
        @(posedge clk);
        #1 started = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Single arrival, held then released.
        arriveSw = 1'b1;
        tick(16);
        arriveSw = 1'b0;
        tick(6);

        // Single departure.
        departSw = 1'b1;
        tick(14);
        departSw = 1'b0;
        tick(6);

        // Simultaneous requests, repeated to exercise arbitration.
        repeat (4) begin
            arriveSw = 1'b1;
            departSw = 1'b1;
            tick(15);
            arriveSw = 1'b0;
            departSw = 1'b0;
            tick(6);
        end

        // Departure pulse during arrival equalisation is ignored.
        arriveSw = 1'b1;
        tick(4);
        departSw = 1'b1;
        tick(2);
        departSw = 1'b0;
        tick(12);
        arriveSw = 1'b0;
        tick(6);

        // Reset during the 4th cycle of departure equalisation, request still held.
        departSw = 1'b1;
        tick(6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(16);
        departSw = 1'b0;
        tick(6);

        // Sub-cycle glitches between edges.
        repeat (3) begin
            @(posedge clk);
            #3 arriveSw = 1'b1;
            #2 arriveSw = 1'b0;
            @(posedge clk);
            #3 departSw = 1'b1;
            #2 departSw = 1'b0;
        end
        tick(6);

        // Randomised traffic with occasional resets.
        repeat (500) begin
            if ($urandom_range(0, 7) == 0) arriveSw = ~arriveSw;
            if ($urandom_range(0, 7) == 0) departSw = ~departSw;
            rst = ($urandom_range(0, 149) == 0);
            tick(1);
        end
        rst = 1'b0;
        arriveSw = 1'b0;
        departSw = 1'b0;
        tick(12);

        @(posedge clk);
        #1 started = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
